// File: rtl/n_risc_pkg.sv
// n_risc_pkg: opcodes, ALU operations and instruction field positions for the n_risc core.
package n_risc_pkg;
  localparam int NREGS = 4;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_BEQZ = 3'd7;
  localparam int OP_HI = 7, OP_LO = 5;
  localparam int RA_HI = 4, RA_LO = 3;
  localparam int RB_HI = 2, RB_LO = 1;
  localparam int IMM_HI = 2, IMM_LO = 0;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_PASSB} alu_op_t;
  function automatic logic [7:0] sext3(input logic [2:0] v);
    return {{5{v[2]}}, v};
  endfunction
endpackage

// File: rtl/n_risc_alu.sv
// n_risc_alu: 8-bit ALU with modulo-256 arithmetic and a zero flag on operand A.
import n_risc_pkg::*;
module n_risc_alu (
  input  alu_op_t     i_op,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [7:0]  SaidaULA,
  output logic        o_zero
);
  always_comb begin
    SaidaULA = i_op == ALU_ADD ? i_a + i_b :
               i_op == ALU_SUB ? i_a - i_b :
               i_op == ALU_AND ? i_a & i_b :
               i_op == ALU_OR  ? i_a | i_b : i_b;
    o_zero = i_a == 8'd0;
  end
endmodule

// File: rtl/n_risc_regfile.sv
// n_risc_regfile: 4x8 register file, two async read ports, one sync write port.
// NRISC_R0_ZERO_EN makes r0 a constant zero by discarding writes to it.
import n_risc_pkg::*;
module n_risc_regfile (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        i_we,
  input  logic [1:0]  i_wa,
  input  logic [7:0]  i_wd,
  input  logic [1:0]  i_ra1,
  input  logic [1:0]  i_ra2,
  output logic [7:0]  DadoLido1,
  output logic [7:0]  DadoLido2
);
  logic [7:0] r_regs [NREGS];
  logic       w_we;
`ifdef NRISC_R0_ZERO_EN
  assign w_we = i_we && i_wa != 2'd0;
`else
  assign w_we = i_we;
`endif
  assign DadoLido1 = r_regs[i_ra1];
  assign DadoLido2 = r_regs[i_ra2];
  always_ff @(posedge Clock) begin
    if (!Reset_n)
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    else if (w_we)
      r_regs[i_wa] <= i_wd;
  end
endmodule

// File: rtl/n_risc.sv
// n_risc: single-cycle 8-bit load/store core; decode and PC live here.
// Define NRISC_R0_ZERO_EN to hardwire r0 to zero.
import n_risc_pkg::*;
module n_risc #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [7:0]  SaidaPC,
  input  logic [7:0]  Instrucao,
  output logic [7:0]  EndMemDados,
  output logic [7:0]  DadoEscritoMem,
  input  logic [7:0]  DadoLidoMem,
  output logic        out_EscReg,
  output logic        out_EscMem,
  output logic        out_LerMem
);
  logic [7:0] r_pc;
  logic [2:0] w_op;
  logic [7:0] w_imm, w_a, w_b, w_alu_b, w_alu_y, w_wd, w_pc_inc, w_pc_next;
  logic       w_zero;
  alu_op_t    w_alu_op;
  assign w_op = Instrucao[OP_HI:OP_LO];
  assign w_imm = sext3(Instrucao[IMM_HI:IMM_LO]);
  always_comb begin
    w_alu_op = w_op == OP_SUB ? ALU_SUB :
               w_op == OP_AND ? ALU_AND :
               w_op == OP_OR  ? ALU_OR  :
               (w_op == OP_ADD || w_op == OP_ADDI) ? ALU_ADD : ALU_PASSB;
    w_alu_b = w_op == OP_ADDI ? w_imm : w_b;
    w_wd = w_op == OP_LW ? DadoLidoMem : w_alu_y;
    w_pc_inc = r_pc + 8'd1;
    w_pc_next = (w_op == OP_BEQZ && w_zero) ? w_pc_inc + w_imm : w_pc_inc;
  end
  // Strobes are squashed during reset so external memory never sees a stray write.
  assign out_EscReg = Reset_n && w_op < OP_SW;
  assign out_EscMem = Reset_n && w_op == OP_SW;
  assign out_LerMem = Reset_n && w_op == OP_LW;
  assign SaidaPC = r_pc;
  assign EndMemDados = w_b;
  assign DadoEscritoMem = w_a;
  always_ff @(posedge Clock) begin
    if (!Reset_n) r_pc <= PC_RESET;
    else r_pc <= w_pc_next;
  end
  n_risc_regfile BancoReg (
    .Clock(Clock), .Reset_n(Reset_n), .i_we(out_EscReg),
    .i_wa(Instrucao[RA_HI:RA_LO]), .i_wd(w_wd),
    .i_ra1(Instrucao[RA_HI:RA_LO]), .i_ra2(Instrucao[RB_HI:RB_LO]),
    .DadoLido1(w_a), .DadoLido2(w_b)
  );
  n_risc_alu ULA (
    .i_op(w_alu_op), .i_a(w_a), .i_b(w_alu_b), .SaidaULA(w_alu_y), .o_zero(w_zero)
  );
endmodule

// File: tb/tb_n_risc.sv
// tb_n_risc: directed checks of the n_risc core with a small data memory model.
module tb_n_risc;
  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Instrucao = 8'h80;
  logic [7:0] DadoLidoMem, SaidaPC, EndMemDados, DadoEscritoMem;
  logic       out_EscReg, out_EscMem, out_LerMem;
  logic [7:0] mem [256];
  int total = 0, bad = 0;

  n_risc dut (
    .Clock(Clock), .Reset_n(Reset_n), .SaidaPC(SaidaPC), .Instrucao(Instrucao),
    .EndMemDados(EndMemDados), .DadoEscritoMem(DadoEscritoMem), .DadoLidoMem(DadoLidoMem),
    .out_EscReg(out_EscReg), .out_EscMem(out_EscMem), .out_LerMem(out_LerMem)
  );

  always #10 Clock = ~Clock;
  assign DadoLidoMem = mem[EndMemDados];
  always @(posedge Clock) if (out_EscMem) mem[EndMemDados] <= DadoEscritoMem;

  task step(input logic [7:0] ins);
    @(negedge Clock);
    Reset_n = 1'b1;
    Instrucao = ins;
    #1;
  endtask

  task peek(input logic [1:0] k, output logic [7:0] v);
    logic [7:0] s;
    s = Instrucao;
    Instrucao = {3'b000, k, 3'b000};
    #1;
    v = dut.BancoReg.DadoLido1;
    Instrucao = s;
    #1;
  endtask

  task reset_core;
    @(negedge Clock);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task test_reset;
    logic [7:0] v;
    @(negedge Clock);
    Reset_n = 1'b0;
    Instrucao = 8'hBA;
    #1;
    total++; if (out_LerMem !== 1'b0) begin bad++; $display("FAIL rst_lermem got=%b exp=0", out_LerMem); end
    total++; if (out_EscReg !== 1'b0) begin bad++; $display("FAIL rst_escreg got=%b exp=0", out_EscReg); end
    Instrucao = 8'hD2;
    #1;
    total++; if (out_EscMem !== 1'b0) begin bad++; $display("FAIL rst_escmem got=%b exp=0", out_EscMem); end
    repeat (2) @(posedge Clock);
    #1;
    total++; if (SaidaPC !== 8'd0) begin bad++; $display("FAIL rst_pc got=%0d exp=0", SaidaPC); end
    for (int k = 0; k < 4; k++) begin
      peek(k[1:0], v);
      total++; if (v !== 8'd0) begin bad++; $display("FAIL rst_r%0d got=%0d exp=0", k, v); end
    end
  endtask

  task test_alu;
    logic [7:0] v;
    reset_core();
    step(8'h8B);
    total++; if (out_EscReg !== 1'b1) begin bad++; $display("FAIL addi_escreg got=%b exp=1", out_EscReg); end
    total++; if (SaidaPC !== 8'd0) begin bad++; $display("FAIL alu_pc0 got=%0d exp=0", SaidaPC); end
    step(8'h97);
    peek(2'd1, v);
    total++; if (v !== 8'd3) begin bad++; $display("FAIL addi_r1 got=%0d exp=3", v); end
    step(8'h0C);
    total++; if (dut.BancoReg.DadoLido2 !== 8'd255) begin bad++; $display("FAIL addi_neg_r2 got=%0d exp=255", dut.BancoReg.DadoLido2); end
    total++; if (dut.ULA.SaidaULA !== 8'd2) begin bad++; $display("FAIL add_ula got=%0d exp=2", dut.ULA.SaidaULA); end
    total++; if (out_EscReg !== 1'b1) begin bad++; $display("FAIL add_escreg got=%b exp=1", out_EscReg); end
    step(8'h32);
    peek(2'd1, v);
    total++; if (v !== 8'd2) begin bad++; $display("FAIL add_r1 got=%0d exp=2", v); end
    total++; if (dut.ULA.SaidaULA !== 8'd253) begin bad++; $display("FAIL sub_ula got=%0d exp=253", dut.ULA.SaidaULA); end
    step(8'h72);
    total++; if (dut.ULA.SaidaULA !== 8'd255) begin bad++; $display("FAIL or_ula got=%0d exp=255", dut.ULA.SaidaULA); end
    step(8'h52);
    total++; if (dut.ULA.SaidaULA !== 8'd2) begin bad++; $display("FAIL and_ula got=%0d exp=2", dut.ULA.SaidaULA); end
    step(8'h0A);
    total++; if (dut.BancoReg.DadoLido1 !== 8'd2 || dut.BancoReg.DadoLido2 !== 8'd2) begin bad++; $display("FAIL rr_read got=%0d/%0d exp=2/2", dut.BancoReg.DadoLido1, dut.BancoReg.DadoLido2); end
    total++; if (dut.ULA.SaidaULA !== 8'd4) begin bad++; $display("FAIL add_self_ula got=%0d exp=4", dut.ULA.SaidaULA); end
    step(8'h0A);
    total++; if (dut.BancoReg.DadoLido1 !== 8'd4) begin bad++; $display("FAIL back_to_back got=%0d exp=4", dut.BancoReg.DadoLido1); end
    total++; if (SaidaPC !== 8'd7) begin bad++; $display("FAIL alu_pc7 got=%0d exp=7", SaidaPC); end
  endtask

  task test_mem;
    logic [7:0] v;
    reset_core();
    step(8'h8A); step(8'h93); step(8'h93); step(8'h91);
    step(8'hD2);
    total++; if (out_EscMem !== 1'b1) begin bad++; $display("FAIL sw_escmem got=%b exp=1", out_EscMem); end
    total++; if (out_LerMem !== 1'b0 || out_EscReg !== 1'b0) begin bad++; $display("FAIL sw_other got=%b%b exp=00", out_LerMem, out_EscReg); end
    total++; if (EndMemDados !== 8'd2) begin bad++; $display("FAIL sw_addr got=%0d exp=2", EndMemDados); end
    total++; if (DadoEscritoMem !== 8'd7) begin bad++; $display("FAIL sw_data got=%0d exp=7", DadoEscritoMem); end
    step(8'hBA);
    total++; if (out_LerMem !== 1'b1 || out_EscMem !== 1'b0 || out_EscReg !== 1'b1) begin bad++; $display("FAIL lw_strobes got=%b%b%b exp=101", out_LerMem, out_EscMem, out_EscReg); end
    total++; if (EndMemDados !== 8'd2) begin bad++; $display("FAIL lw_addr got=%0d exp=2", EndMemDados); end
    step(8'h80);
    peek(2'd3, v);
    total++; if (v !== 8'd7) begin bad++; $display("FAIL lw_r3 got=%0d exp=7", v); end
  endtask

  task test_branch;
    reset_core();
    step(8'h8A); step(8'h88); step(8'h88); step(8'h88); step(8'h88);
    step(8'hE2);
    total++; if (SaidaPC !== 8'd5) begin bad++; $display("FAIL br_pc5 got=%0d exp=5", SaidaPC); end
    total++; if (out_EscReg !== 1'b0 || out_EscMem !== 1'b0 || out_LerMem !== 1'b0) begin bad++; $display("FAIL br_strobes got=%b%b%b exp=000", out_EscReg, out_EscMem, out_LerMem); end
    step(8'hEA);
    total++; if (SaidaPC !== 8'd8) begin bad++; $display("FAIL br_taken got=%0d exp=8", SaidaPC); end
    step(8'hE7);
    total++; if (SaidaPC !== 8'd9) begin bad++; $display("FAIL br_not_taken got=%0d exp=9", SaidaPC); end
    step(8'hE7);
    total++; if (SaidaPC !== 8'd9) begin bad++; $display("FAIL br_self_loop got=%0d exp=9", SaidaPC); end
    step(8'h80);
    total++; if (SaidaPC !== 8'd9) begin bad++; $display("FAIL br_hold got=%0d exp=9", SaidaPC); end
    step(8'h80);
    total++; if (SaidaPC !== 8'd10) begin bad++; $display("FAIL br_after got=%0d exp=10", SaidaPC); end
  endtask

  task test_wrap;
    logic [7:0] v;
    reset_core();
    step(8'hE7);
    step(8'hE6);
    total++; if (SaidaPC !== 8'd0) begin bad++; $display("FAIL wrap_self0 got=%0d exp=0", SaidaPC); end
    step(8'h80);
    total++; if (SaidaPC !== 8'd255) begin bad++; $display("FAIL wrap_back got=%0d exp=255", SaidaPC); end
    step(8'h8F);
    total++; if (SaidaPC !== 8'd0) begin bad++; $display("FAIL wrap_fwd got=%0d exp=0", SaidaPC); end
    step(8'h89);
    peek(2'd1, v);
    total++; if (v !== 8'd255) begin bad++; $display("FAIL wrap_r1_neg got=%0d exp=255", v); end
    step(8'h80);
    peek(2'd1, v);
    total++; if (v !== 8'd0) begin bad++; $display("FAIL wrap_r1_zero got=%0d exp=0", v); end
  endtask

  task test_r0;
    logic [7:0] v, exp_r0;
`ifdef NRISC_R0_ZERO_EN
    exp_r0 = 8'd0;
`else
    exp_r0 = 8'd3;
`endif
    reset_core();
    step(8'h83);
    total++; if (out_EscReg !== 1'b1) begin bad++; $display("FAIL r0_escreg got=%b exp=1", out_EscReg); end
    step(8'h80);
    peek(2'd0, v);
    total++; if (v !== exp_r0) begin bad++; $display("FAIL r0_value got=%0d exp=%0d", v, exp_r0); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_wrap();
    test_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
